// File: rtl/ks_seq_pkg.sv
// Shared types and constants for the Karplus-Strong note sequencer.
package ks_seq_pkg;

  localparam int SEQ_NUM_STEPS  = 8;
  localparam int SEQ_STEP_W     = 3;
  localparam int SEQ_DATA_WIDTH = 8;
  localparam int SEQ_TEMPO_W    = 16;

  // A pattern entry is {rest, period}; the rest flag sits just above the period.
  localparam int SEQ_ENTRY_W = SEQ_DATA_WIDTH + 1;
  localparam int REST_BIT    = SEQ_DATA_WIDTH;

  // Zero-valued tempo / pluck lengths are treated as this many ticks.
  localparam int SEQ_MIN_LEN = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_PLUCK = 2'd2,
    ST_HOLD  = 2'd3
  } ks_state_e;

  // Builds a pattern entry from its rest flag and period.
  function automatic logic [SEQ_ENTRY_W-1:0] mk_entry(input logic rest,
                                                      input logic [SEQ_DATA_WIDTH-1:0] period);
    logic [SEQ_ENTRY_W-1:0] e;
    e = '0;
    e[SEQ_DATA_WIDTH-1:0] = period;
    e[REST_BIT] = rest;
    return e;
  endfunction

endpackage

// File: rtl/ks_note_sequencer_if.sv
// Pattern write port from the SPI register map into the sequencer.
// Handshake: no backpressure; one entry is written on every clk edge where
// wr_en_i is high, using wr_addr_i/wr_data_i sampled on that same edge.
interface ks_note_sequencer_if #(
  parameter int STEP_W  = 3,
  parameter int ENTRY_W = 9
);
  logic               wr_en_i;
  logic [STEP_W-1:0]  wr_addr_i;
  logic [ENTRY_W-1:0] wr_data_i;

  modport master (output wr_en_i, output wr_addr_i, output wr_data_i);
  modport slave  (input  wr_en_i, input  wr_addr_i, input  wr_data_i);
endinterface

// File: rtl/ks_seq_step_mem.sv
// Pattern register file: synchronous write, combinational read, cleared on reset.
module ks_seq_step_mem
  import ks_seq_pkg::*;
#(
  parameter int NUM_STEPS = SEQ_NUM_STEPS,
  parameter int STEP_W    = SEQ_STEP_W,
  parameter int ENTRY_W   = SEQ_ENTRY_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en_i,
  input  logic [STEP_W-1:0]  wr_addr_i,
  input  logic [ENTRY_W-1:0] wr_data_i,
  input  logic [STEP_W-1:0]  rd_addr_i,
  output logic [ENTRY_W-1:0] rd_data_o
);

  logic [ENTRY_W-1:0] mem_q [NUM_STEPS];

  // Entry storage; a read of the address being written returns the old value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STEPS; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/ks_note_sequencer.sv
// Step sequencer: walks the pattern, presents each period to ks_string and
// issues a pluck pulse timed in sample-rate ticks.
module ks_note_sequencer
  import ks_seq_pkg::*;
#(
  parameter int NUM_STEPS  = SEQ_NUM_STEPS,
  parameter int STEP_W     = SEQ_STEP_W,
  parameter int DATA_WIDTH = SEQ_DATA_WIDTH,
  parameter int TEMPO_W    = SEQ_TEMPO_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  loop_en_i,
  input  logic [STEP_W-1:0]     last_step_i,
  input  logic [TEMPO_W-1:0]    tempo_i,
  input  logic [7:0]            pluck_len_i,
  ks_note_sequencer_if.slave    wr_if,
  output logic [DATA_WIDTH-1:0] period_o,
  output logic                  pluck_o,
  output logic                  busy_o,
  output logic [STEP_W-1:0]     step_o,
  output logic                  step_strobe_o,
  output ks_state_e             state_o
);

  localparam int EntryW = DATA_WIDTH + 1;

  ks_state_e             state_q, state_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [TEMPO_W-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] period_q, period_d;
  logic                  pluck_q, pluck_d;
  logic                  strobe_q, strobe_d;
  logic                  busy_q, busy_d;

  logic [EntryW-1:0]     rd_data;
  logic [TEMPO_W-1:0]    tlen;
  logic [7:0]            plen;
  logic [TEMPO_W:0]      cnt_inc;
  logic                  playing;
  logic                  step_end;
  logic                  pluck_end;
  logic                  at_last;
  logic                  rest_sel;

  ks_seq_step_mem #(
    .NUM_STEPS (NUM_STEPS),
    .STEP_W    (STEP_W),
    .ENTRY_W   (EntryW)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_if.wr_en_i),
    .wr_addr_i (wr_if.wr_addr_i),
    .wr_data_i (wr_if.wr_data_i),
    .rd_addr_i (step_q),
    .rd_data_o (rd_data)
  );

  // Zero lengths behave as one tick so a step can never stall.
  assign tlen      = (tempo_i == '0) ? TEMPO_W'(SEQ_MIN_LEN) : tempo_i;
  assign plen      = (pluck_len_i == '0) ? 8'(SEQ_MIN_LEN) : pluck_len_i;
  assign cnt_inc   = {1'b0, cnt_q} + (TEMPO_W + 1)'(1);
  assign playing   = (state_q == ST_PLUCK) || (state_q == ST_HOLD);
  // ">=" rather than "==" so a live shortening of tempo/pluck length cannot strand the counter.
  assign step_end  = playing && tick_i && (cnt_inc >= {1'b0, tlen});
  assign pluck_end = (state_q == ST_PLUCK) && tick_i && (cnt_inc >= (TEMPO_W + 1)'(plen));
  assign at_last   = (step_q == last_step_i);
  assign rest_sel  = rd_data[DATA_WIDTH];

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      step_q   <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      pluck_q  <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pluck_q  <= pluck_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic; step end outranks pluck end, stop outranks everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_LOAD;
      ST_LOAD:  state_d = rest_sel ? ST_HOLD : ST_PLUCK;
      ST_PLUCK: begin
        if (step_end)       state_d = (at_last && !loop_en_i) ? ST_IDLE : ST_LOAD;
        else if (pluck_end) state_d = ST_HOLD;
      end
      ST_HOLD:  if (step_end) state_d = (at_last && !loop_en_i) ? ST_IDLE : ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase
    if (stop_i) state_d = ST_IDLE;
  end

  // Datapath and output next values; a stop freezes step and period.
  always_comb begin
    step_d   = step_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    if (!stop_i) begin
      if ((state_q == ST_IDLE) && start_i) step_d = '0;
      if (state_q == ST_LOAD) begin
        period_d = rd_data[DATA_WIDTH-1:0];
        cnt_d    = '0;
      end else if (playing && tick_i) begin
        cnt_d = cnt_inc[TEMPO_W-1:0];
      end
      if (step_end) begin
        if (!at_last)       step_d = step_q + STEP_W'(1);
        else if (loop_en_i) step_d = '0;
      end
    end
    pluck_d  = (state_d == ST_PLUCK);
    strobe_d = (state_d == ST_LOAD);
    busy_d   = (state_d != ST_IDLE);
  end

  assign period_o      = period_q;
  assign pluck_o       = pluck_q;
  assign busy_o        = busy_q;
  assign step_o        = step_q;
  assign step_strobe_o = strobe_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_ks_note_sequencer.sv
// Directed bench for ks_note_sequencer: per-step vector tables plus
// hand-written sequences for stop, restart, reset and write corners.
module tb_ks_note_sequencer;
  import ks_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_i = 1'b0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        loop_en_i = 1'b0;
  logic [2:0]  last_step_i = '0;
  logic [15:0] tempo_i = '0;
  logic [7:0]  pluck_len_i = '0;
  logic [7:0]  period_o;
  logic        pluck_o;
  logic        busy_o;
  logic [2:0]  step_o;
  logic        step_strobe_o;
  ks_state_e   state_o;

  ks_note_sequencer_if #(.STEP_W(3), .ENTRY_W(9)) wr_if ();

  ks_note_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_i        (tick_i),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .loop_en_i     (loop_en_i),
    .last_step_i   (last_step_i),
    .tempo_i       (tempo_i),
    .pluck_len_i   (pluck_len_i),
    .wr_if         (wr_if.slave),
    .period_o      (period_o),
    .pluck_o       (pluck_o),
    .busy_o        (busy_o),
    .step_o        (step_o),
    .step_strobe_o (step_strobe_o),
    .state_o       (state_o)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int strobe_cnt = 0;

  always @(negedge clk) if (step_strobe_o === 1'b1) strobe_cnt++;

  typedef struct {
    logic [2:0]  step;
    logic [7:0]  period;
    logic        rest;
    logic [15:0] tempo_in;
    logic [7:0]  plen_in;
    int          tlen;
    int          plen;
    logic        last;
    int          wr_when;   // 0 none, 1 during LOAD clk, 2 on first tick
    logic [2:0]  wr_addr;
    logic [8:0]  wr_data;
    logic        tick_load;
  } step_vec_t;

  step_vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clk with the given tick level; outputs are sampled 1 ns after the edge.
  task automatic cyc(input logic t);
    tick_i = t;
    @(posedge clk);
    #1;
    tick_i = 1'b0;
  endtask

  task automatic wr_entry(input logic [2:0] a, input logic [8:0] d);
    wr_if.wr_en_i = 1'b1;
    wr_if.wr_addr_i = a;
    wr_if.wr_data_i = d;
    cyc(1'b0);
    wr_if.wr_en_i = 1'b0;
  endtask

  task automatic add_vec(input logic [2:0] step, input logic [7:0] period, input logic rest,
                         input logic [15:0] tempo_in, input logic [7:0] plen_in,
                         input int tlen, input int plen, input logic last,
                         input int wr_when, input logic [2:0] wr_addr, input logic [8:0] wr_data,
                         input logic tick_load);
    step_vec_t v;
    v.step = step; v.period = period; v.rest = rest;
    v.tempo_in = tempo_in; v.plen_in = plen_in;
    v.tlen = tlen; v.plen = plen; v.last = last;
    v.wr_when = wr_when; v.wr_addr = wr_addr; v.wr_data = wr_data;
    v.tick_load = tick_load;
    tbl.push_back(v);
  endtask

  // Driver: plays one step starting from a sampled LOAD state, checking pluck per tick.
  task automatic play_step(input step_vec_t v);
    tempo_i = v.tempo_in;
    pluck_len_i = v.plen_in;
    chk("load_state", 32'(state_o), 32'(ST_LOAD));
    chk("load_step", 32'(step_o), 32'(v.step));
    chk("load_strobe", 32'(step_strobe_o), 32'd1);
    if (v.wr_when == 1) begin
      wr_if.wr_en_i = 1'b1; wr_if.wr_addr_i = v.wr_addr; wr_if.wr_data_i = v.wr_data;
    end
    cyc(v.tick_load);
    wr_if.wr_en_i = 1'b0;
    chk("step_period", 32'(period_o), 32'(v.period));
    chk("step_pluck_start", 32'(pluck_o), 32'(!v.rest));
    chk("strobe_low", 32'(step_strobe_o), 32'd0);
    for (int k = 1; k <= v.tlen; k++) begin
      if (k == 1 && v.wr_when == 2) begin
        wr_if.wr_en_i = 1'b1; wr_if.wr_addr_i = v.wr_addr; wr_if.wr_data_i = v.wr_data;
      end
      cyc(1'b1);
      wr_if.wr_en_i = 1'b0;
      if (k < v.tlen) begin
        chk("pluck_tick", 32'(pluck_o), 32'(!v.rest && (k < v.plen)));
        chk("period_hold", 32'(period_o), 32'(v.period));
        if (k == 1) begin
          cyc(1'b0);
          chk("pluck_no_tick", 32'(pluck_o), 32'(!v.rest && (k < v.plen)));
        end
      end
    end
    chk("step_end_pluck", 32'(pluck_o), 32'd0);
    if (v.last) begin
      chk("end_state", 32'(state_o), 32'(ST_IDLE));
      chk("end_busy", 32'(busy_o), 32'd0);
      chk("end_period", 32'(period_o), 32'(v.period));
      chk("end_step", 32'(step_o), 32'(v.step));
    end else begin
      chk("next_state", 32'(state_o), 32'(ST_LOAD));
      chk("next_busy", 32'(busy_o), 32'd1);
    end
  endtask

  task automatic run_table(input logic loop, input logic [2:0] last);
    loop_en_i = loop;
    last_step_i = last;
    if (tbl.size() > 0) begin
      tempo_i = tbl[0].tempo_in;
      pluck_len_i = tbl[0].plen_in;
    end
    start_i = 1'b1;
    cyc(1'b0);
    start_i = 1'b0;
    foreach (tbl[i]) play_step(tbl[i]);
    tbl.delete();
  endtask

  // Bound on total sim time in case something stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  int s0;

  initial begin
    wr_if.wr_en_i = 1'b0;
    wr_if.wr_addr_i = '0;
    wr_if.wr_data_i = '0;

    // Reset state
    rst_n = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    chk("rst_state", 32'(state_o), 32'(ST_IDLE));
    chk("rst_period", 32'(period_o), 32'd0);
    chk("rst_pluck", 32'(pluck_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_step", 32'(step_o), 32'd0);
    chk("rst_strobe", 32'(step_strobe_o), 32'd0);
    rst_n = 1'b1;
    cyc(1'b0);

    wr_entry(3'd0, mk_entry(1'b0, 8'h20));
    wr_entry(3'd1, mk_entry(1'b1, 8'h30));
    wr_entry(3'd2, mk_entry(1'b0, 8'h40));

    // Three-step pattern, no loop: 12 ticks then idle, three strobes
    s0 = strobe_cnt;
    add_vec(3'd0, 8'h20, 1'b0, 16'd4, 8'd2, 4, 2, 1'b0, 0, 3'd0, 9'h0, 1'b0);
    add_vec(3'd1, 8'h30, 1'b1, 16'd4, 8'd2, 4, 2, 1'b0, 0, 3'd0, 9'h0, 1'b0);
    add_vec(3'd2, 8'h40, 1'b0, 16'd4, 8'd2, 4, 2, 1'b1, 0, 3'd0, 9'h0, 1'b0);
    run_table(1'b0, 3'd2);
    cyc(1'b0);
    chk("strobe_count", 32'(strobe_cnt - s0), 32'd3);

    // Looping pattern 0,1,2,0,1 then stop during step 1
    add_vec(3'd0, 8'h20, 1'b0, 16'd4, 8'd2, 4, 2, 1'b0, 0, 3'd0, 9'h0, 1'b0);
    add_vec(3'd1, 8'h30, 1'b1, 16'd4, 8'd2, 4, 2, 1'b0, 0, 3'd0, 9'h0, 1'b0);
    add_vec(3'd2, 8'h40, 1'b0, 16'd4, 8'd2, 4, 2, 1'b0, 0, 3'd0, 9'h0, 1'b0);
    add_vec(3'd0, 8'h20, 1'b0, 16'd4, 8'd2, 4, 2, 1'b0, 0, 3'd0, 9'h0, 1'b0);
    run_table(1'b1, 3'd2);
    chk("loop_step1", 32'(step_o), 32'd1);
    cyc(1'b0);
    chk("loop_period1", 32'(period_o), 32'h30);
    cyc(1'b1);
    stop_i = 1'b1;
    cyc(1'b0);
    stop_i = 1'b0;
    chk("stop_state", 32'(state_o), 32'(ST_IDLE));
    chk("stop_busy", 32'(busy_o), 32'd0);
    chk("stop_pluck", 32'(pluck_o), 32'd0);
    chk("stop_period", 32'(period_o), 32'h30);
    chk("stop_step", 32'(step_o), 32'd1);

    // Writes during play: mid-step write to 1, write coincident with LOAD of 2
    add_vec(3'd0, 8'h20, 1'b0, 16'd4, 8'd2, 4, 2, 1'b0, 0, 3'd0, 9'h0, 1'b0);
    add_vec(3'd1, 8'h30, 1'b1, 16'd4, 8'd2, 4, 2, 1'b0, 2, 3'd1, 9'h055, 1'b0);
    add_vec(3'd2, 8'h40, 1'b0, 16'd4, 8'd2, 4, 2, 1'b0, 1, 3'd2, 9'h066, 1'b0);
    add_vec(3'd0, 8'h20, 1'b0, 16'd4, 8'd2, 4, 2, 1'b0, 0, 3'd0, 9'h0, 1'b0);
    add_vec(3'd1, 8'h55, 1'b0, 16'd4, 8'd2, 4, 2, 1'b0, 0, 3'd0, 9'h0, 1'b0);
    add_vec(3'd2, 8'h66, 1'b0, 16'd4, 8'd2, 4, 2, 1'b0, 0, 3'd0, 9'h0, 1'b0);
    run_table(1'b1, 3'd2);
    stop_i = 1'b1;
    cyc(1'b0);
    stop_i = 1'b0;
    chk("stop_in_load_state", 32'(state_o), 32'(ST_IDLE));
    chk("stop_in_load_period", 32'(period_o), 32'h66);

    // Zero tempo and pluck length clamp to one tick; tick during LOAD ignored
    add_vec(3'd0, 8'h20, 1'b0, 16'd0, 8'd0, 1, 1, 1'b0, 0, 3'd0, 9'h0, 1'b1);
    add_vec(3'd1, 8'h55, 1'b0, 16'd0, 8'd0, 1, 1, 1'b1, 0, 3'd0, 9'h0, 1'b1);
    run_table(1'b0, 3'd1);

    // Pluck longer than step: high all 3 ticks, drops at step end, rises after LOAD
    add_vec(3'd0, 8'h20, 1'b0, 16'd3, 8'd9, 3, 9, 1'b0, 0, 3'd0, 9'h0, 1'b0);
    add_vec(3'd1, 8'h55, 1'b0, 16'd3, 8'd9, 3, 9, 1'b1, 0, 3'd0, 9'h0, 1'b0);
    run_table(1'b0, 3'd1);

    // start and stop together while idle
    start_i = 1'b1;
    stop_i = 1'b1;
    cyc(1'b0);
    start_i = 1'b0;
    stop_i = 1'b0;
    chk("start_stop_state", 32'(state_o), 32'(ST_IDLE));
    chk("start_stop_busy", 32'(busy_o), 32'd0);

    // start while busy is ignored
    loop_en_i = 1'b0;
    last_step_i = 3'd2;
    tempo_i = 16'd4;
    pluck_len_i = 8'd2;
    start_i = 1'b1;
    cyc(1'b0);
    start_i = 1'b0;
    cyc(1'b0);
    cyc(1'b1);
    start_i = 1'b1;
    cyc(1'b1);
    start_i = 1'b0;
    chk("restart_step", 32'(step_o), 32'd0);
    chk("restart_state", 32'(state_o), 32'(ST_HOLD));
    stop_i = 1'b1;
    cyc(1'b0);
    stop_i = 1'b0;

    // Reset mid-PLUCK clears outputs and pattern memory
    start_i = 1'b1;
    cyc(1'b0);
    start_i = 1'b0;
    cyc(1'b0);
    chk("pre_reset_pluck", 32'(pluck_o), 32'd1);
    rst_n = 1'b0;
    cyc(1'b0);
    rst_n = 1'b1;
    chk("mid_rst_state", 32'(state_o), 32'(ST_IDLE));
    chk("mid_rst_pluck", 32'(pluck_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_period", 32'(period_o), 32'd0);
    chk("mid_rst_step", 32'(step_o), 32'd0);
    add_vec(3'd0, 8'h00, 1'b0, 16'd1, 8'd1, 1, 1, 1'b0, 0, 3'd0, 9'h0, 1'b0);
    add_vec(3'd1, 8'h00, 1'b0, 16'd1, 8'd1, 1, 1, 1'b1, 0, 3'd0, 9'h0, 1'b0);
    run_table(1'b0, 3'd1);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
